// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_responder                                             |
// | Description : Memory-side end of the MEM-stage load/store port. Accepts  |
// |               one word access per handshake, inserts WAIT_CYCLES wait    |
// |               states, commits the store or returns load data, and holds  |
// |               stall high while the access is pending.                    |
// | Option      : DMEM_CYCLE_CNT_EN maps a free-running 32-bit cycle counter |
// |               onto ADDR_CYC (read-only, stores there are discarded).     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] ADDR_CYC    = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int         c_IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] c_CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_cnt;
    logic [3:0]         w_next_cnt;

    logic               r_we;
    logic [15:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic [31:0]        r_mem [DEPTH];

    logic               w_idle;
    logic               w_acc_we;
    logic [15:0]        w_acc_addr;
    logic [31:0]        w_acc_wdata;
    logic [3:0]         w_acc_be;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_mis;
    logic               w_is_cyc;
    logic [31:0]        w_cyc_val;
    logic               w_commit;
    logic               w_mem_we;
    logic               w_unused_bits;

    assign w_idle = (r_state == c_S_IDLE);

    // With zero wait states the commit edge is the accept edge, so the access
    // fields come straight from the request port while IDLE.
    assign w_acc_we    = w_idle ? req_we          : r_we;
    assign w_acc_addr  = w_idle ? req_addr[15:0]  : r_addr;
    assign w_acc_wdata = w_idle ? req_wdata       : r_wdata;
    assign w_acc_be    = w_idle ? req_be          : r_be;

    assign w_idx = w_acc_addr[c_IDX_W+1:2];
    assign w_mis = |w_acc_addr[1:0];

    // Commit on the edge that enters RESP; a synchronous reset on that edge wins.
    assign w_commit = (w_next_state == c_S_RESP) && (r_state != c_S_RESP) && !rst;

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] r_cyc;

    // Free-running cycle counter, readable at ADDR_CYC.
    always_ff @(posedge clk) begin
        if (rst) r_cyc <= 32'd0;
        else     r_cyc <= r_cyc + 32'd1;
    end

    assign w_is_cyc  = (w_acc_addr == ADDR_CYC);
    assign w_cyc_val = r_cyc;
`else
    assign w_is_cyc  = 1'b0;
    assign w_cyc_val = 32'd0;
`endif

    assign w_mem_we = w_commit && w_acc_we && !w_mis && !w_is_cyc;

    // Bits outside the decoded index are intentionally ignored (address wrap).
    assign w_unused_bits = ^{req_addr[31:16], r_addr, ADDR_CYC};

    // State and wait-count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state and wait-count logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (req_valid) begin
                    w_next_state = (WAIT_CYCLES == 0) ? c_S_RESP : c_S_WAIT;
                    w_next_cnt   = c_CNT_INIT;
                end
            end
            c_S_WAIT: begin
                if (r_cnt == 4'd0) w_next_state = c_S_RESP;
                else               w_next_cnt   = r_cnt - 4'd1;
            end
            c_S_RESP: w_next_state = c_S_IDLE;
            default:  w_next_state = c_S_IDLE;
        endcase
    end

    // Capture the request fields at accept; they are ignored afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= 16'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
        end else if (w_idle && req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr[15:0];
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Response data and error, registered on the commit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err <= w_mis;
            if (w_mis || w_acc_we) r_rdata <= 32'd0;
            else if (w_is_cyc)     r_rdata <= w_cyc_val;
            else                   r_rdata <= r_mem[w_idx];
        end else if (r_state == c_S_RESP) begin
            r_err <= 1'b0;
        end
    end

    // Byte-lane store into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready = w_idle;
    assign rsp_valid = (r_state == c_S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign stall     = (w_idle && req_valid) || (r_state == c_S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dmem_responder                                          |
// | Description : Self-checking bench for dmem_responder: vector table with  |
// |               a response scoreboard, plus reset-abort and cycle-counter  |
// |               sequences (DMEM_CYCLE_CNT_EN selects the variant).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

    localparam int c_DEPTH       = 1024;
    localparam int c_WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    dmem_responder #(
        .DEPTH       (c_DEPTH),
        .WAIT_CYCLES (c_WAIT_CYCLES),
        .ADDR_CYC    (16'hFFFC)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_rdata = 32'd0;
    int          last_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop and compare on every response pulse.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                e = sb.pop_front();
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                if (e.chk) check("rsp_rdata", rsp_rdata, e.rdata);
            end
            last_rdata = rsp_rdata;
            last_cyc   = cyc;
        end
    end

    // One complete access: drive, scramble inputs while pending, check latency and stall.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata,
                          input logic exp_err, input logic chk);
        int n;
        int stalls;
        bit got;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        sb.push_back('{rdata: exp_rdata, err: exp_err, chk: chk});
        #1;
        stalls = stall ? 1 : 0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1'b1;
            else if (stall) stalls++;
        end
        check("latency", got ? 32'(n) : 32'hFFFF_FFFF, 32'(c_WAIT_CYCLES + 1));
        check("stall_cycles", 32'(stalls), 32'(c_WAIT_CYCLES + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] c1;
        int          k1;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;

        // we, addr, wdata, be, expected rdata, expected err
        vecs.push_back('{1'b1, 32'h0000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 32'h0010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0020, 32'h11223344, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'h0020, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b0, 32'h0022, 32'h0,        4'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 32'h0023, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b1, 32'h0020, 32'h55555555, 4'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b1, 32'h1004, 32'h00000005, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0004, 32'h0,        4'h0, 32'h00000005, 1'b0});
        vecs.push_back('{1'b1, 32'h0040, 32'h12345678, 4'hF, 32'h0, 1'b0});
`ifndef DMEM_CYCLE_CNT_EN
        vecs.push_back('{1'b1, 32'hFFFC, 32'h00000007, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFC, 32'h0,        4'h0, 32'h00000007, 1'b0});
`endif

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_stall",     {31'd0, stall},     32'd0);
        check("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("reset_rsp_rdata", rsp_rdata,          32'd0);

        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                   vecs[i].rdata, vecs[i].err, 1'b1);
        end

        // Reset during the WAIT of a store aborts it.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0040;
        req_wdata = 32'h99999999;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_stall",     {31'd0, stall},     32'd0);
        repeat (4) @(negedge clk);
        access(1'b0, 32'h0040, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b1);

`ifdef DMEM_CYCLE_CNT_EN
        // Counter reads track elapsed cycles; a store to it is discarded.
        access(1'b0, 32'hFFFC, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        #1;
        c1 = last_rdata;
        k1 = last_cyc;
        repeat (5) @(negedge clk);
        access(1'b1, 32'hFFFC, 32'h7, 4'hF, 32'h0, 1'b0, 1'b1);
        access(1'b0, 32'hFFFC, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("cycle_delta", last_rdata - c1, 32'(last_cyc - k1));
`else
        c1 = 32'd0;
        k1 = 0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
